morse_symbol_generator: RTL

Converts one PS/2 scan-code-set-2 make code per handshake into a timed Morse keying signal. It is the output stage after the keyboard byte buffer. The buffer presents buffered make codes on a valid/ready interface; this block looks each code up, then drives the dot, dash and gap timing on a single output pin. Unsupported codes are dropped and flagged.

---
 rtl/morse_symbol_generator_pkg.sv | 92 +++++++++
 rtl/morse_unit_timer.sv | 47 ++++
 rtl/morse_symbol_generator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/morse_symbol_generator_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared types and constants for the Morse symbol generator:
//   - FSM state enum
//   - PS/2 set-2 special scan codes
//   - pattern record returned by the character lookup
//   - morse_lookup(): set-2 make code -> Morse pattern (A-Z, 0-9, space)
// Pattern bits are left-aligned: element 0 (sent first) lives in bits[4],
// element i in bits[4-i]; 1 = dash, 0 = dot.
// -----------------------------------------------------------------------------
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_MARK     = 3'd2,
    ST_ELEM_GAP = 3'd3,
    ST_CHAR_GAP = 3'd4,
    ST_WORD_GAP = 3'd5
  } morse_state_t;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef struct packed {
    logic       valid;
    logic       is_space;
    logic [2:0] len;
    logic [4:0] bits;
  } morse_pat_t;

  function automatic morse_pat_t mk_pat(input logic [2:0] len, input logic [4:0] bits);
    morse_pat_t p;
    p.valid    = 1'b1;
    p.is_space = 1'b0;
    p.len      = len;
    p.bits     = bits;
    return p;
  endfunction

  function automatic morse_pat_t morse_lookup(input logic [7:0] scancode);
    morse_pat_t p;
    p = '0;
    case (scancode)
      8'h1C: p = mk_pat(3'd2, 5'b01000); // A .-
      8'h32: p = mk_pat(3'd4, 5'b10000); // B -...
      8'h21: p = mk_pat(3'd4, 5'b10100); // C -.-.
      8'h23: p = mk_pat(3'd3, 5'b10000); // D -..
      8'h24: p = mk_pat(3'd1, 5'b00000); // E .
      8'h2B: p = mk_pat(3'd4, 5'b00100); // F ..-.
      8'h34: p = mk_pat(3'd3, 5'b11000); // G --.
      8'h33: p = mk_pat(3'd4, 5'b00000); // H ....
      8'h43: p = mk_pat(3'd2, 5'b00000); // I ..
      8'h3B: p = mk_pat(3'd4, 5'b01110); // J .---
      8'h42: p = mk_pat(3'd3, 5'b10100); // K -.-
      8'h4B: p = mk_pat(3'd4, 5'b01000); // L .-..
      8'h3A: p = mk_pat(3'd2, 5'b11000); // M --
      8'h31: p = mk_pat(3'd2, 5'b10000); // N -.
      8'h44: p = mk_pat(3'd3, 5'b11100); // O ---
      8'h4D: p = mk_pat(3'd4, 5'b01100); // P .--.
      8'h15: p = mk_pat(3'd4, 5'b11010); // Q --.-
      8'h2D: p = mk_pat(3'd3, 5'b01000); // R .-.
      8'h1B: p = mk_pat(3'd3, 5'b00000); // S ...
      8'h2C: p = mk_pat(3'd1, 5'b10000); // T -
      8'h3C: p = mk_pat(3'd3, 5'b00100); // U ..-
      8'h2A: p = mk_pat(3'd4, 5'b00010); // V ...-
      8'h1D: p = mk_pat(3'd3, 5'b01100); // W .--
      8'h22: p = mk_pat(3'd4, 5'b10010); // X -..-
      8'h35: p = mk_pat(3'd4, 5'b10110); // Y -.--
      8'h1A: p = mk_pat(3'd4, 5'b11000); // Z --..
      8'h45: p = mk_pat(3'd5, 5'b11111); // 0
      8'h16: p = mk_pat(3'd5, 5'b01111); // 1
      8'h1E: p = mk_pat(3'd5, 5'b00111); // 2
      8'h26: p = mk_pat(3'd5, 5'b00011); // 3
      8'h25: p = mk_pat(3'd5, 5'b00001); // 4
      8'h2E: p = mk_pat(3'd5, 5'b00000); // 5
      8'h36: p = mk_pat(3'd5, 5'b10000); // 6
      8'h3D: p = mk_pat(3'd5, 5'b11000); // 7
      8'h3E: p = mk_pat(3'd5, 5'b11100); // 8
      8'h46: p = mk_pat(3'd5, 5'b11110); // 9
      SC_SPACE: begin
        p.valid    = 1'b1;
        p.is_space = 1'b1;
      end
      // SC_EXT, SC_BREAK and everything else stay invalid
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Prescaler (0..UNIT_CYCLES-1) plus 3-bit unit counter. done_o is high in the
// last clk cycle of a target_units_i * UNIT_CYCLES interval. clear_i restarts
// the interval on the next edge.
// Ports:
//   clk, rst        clock, async active-high reset
//   clear_i         synchronous restart of prescaler and unit counter
//   target_units_i  interval length in units (1..7)
//   done_o          last cycle of the interval
// -----------------------------------------------------------------------------
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 1_200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic [2:0] target_units_i,
  output logic       done_o
);

  localparam int PW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_units;
  logic          w_unit_end;

  assign w_unit_end = (r_presc == PRESC_LAST);
  assign done_o     = w_unit_end && (r_units == (target_units_i - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_units <= '0;
    end else if (clear_i) begin
      r_presc <= '0;
      r_units <= '0;
    end else if (w_unit_end) begin
      r_presc <= '0;
      r_units <= r_units + 3'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/morse_symbol_generator.sv
// -----------------------------------------------------------------------------
// morse_symbol_generator
// Takes one PS/2 set-2 make code per valid/ready handshake and keys it out as
// Morse on morse_o. Space produces a word gap; unsupported codes are dropped
// with a one-cycle unsupported_o pulse.
// Optional feature: define MORSE_SIDETONE_EN to add sidetone_o, a square wave
// (half period TONE_HALF_PERIOD clk cycles) that runs only during marks.
// Ports:
//   clk, rst           clock, async active-high reset
//   scancode_i         set-2 make code
//   scancode_valid_i   scancode_i valid
//   scancode_ready_o   ready to accept a code (IDLE)
//   morse_o            keying output, 1 = mark
//   busy_o             symbol or gap in progress
//   unsupported_o      pulse when a code is dropped
//   sidetone_o         sidetone square wave (MORSE_SIDETONE_EN only)
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | ready, waiting for a handshake
// LOAD      | one cycle: look up the latched code
// MARK      | key down for one element (1 or 3 units)
// ELEM_GAP  | 1 unit low between elements
// CHAR_GAP  | 3 units low after the last element
// WORD_GAP  | 7 units low for a space
// -----------------------------------------------------------------------------
module morse_symbol_generator
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 1_200_000,
  parameter int TONE_HALF_PERIOD = 10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode_i,
  input  logic       scancode_valid_i,
  output logic       scancode_ready_o,
  output logic       morse_o,
  output logic       busy_o,
  output logic       unsupported_o
`ifdef MORSE_SIDETONE_EN
  ,
  output logic       sidetone_o
`endif
);

  if (UNIT_CYCLES < 2) begin : g_bad_unit
    $error("UNIT_CYCLES must be >= 2");
  end
  if (TONE_HALF_PERIOD < 1) begin : g_bad_tone
    $error("TONE_HALF_PERIOD must be >= 1");
  end

  morse_state_t r_state, w_next_state;
  logic [7:0]   r_code;
  logic [2:0]   r_elem;
  morse_pat_t   w_pat;
  logic         w_is_dash;
  logic         w_last_elem;
  logic [2:0]   w_target_units;
  logic         w_clear;
  logic         w_done;

  assign w_pat       = morse_lookup(r_code);
  assign w_is_dash   = w_pat.bits[3'd4 - r_elem];
  assign w_last_elem = (r_elem == (w_pat.len - 3'd1));

  always_comb begin
    w_target_units = 3'd1;
    case (r_state)
      ST_MARK:     w_target_units = w_is_dash ? 3'd3 : 3'd1;
      ST_ELEM_GAP: w_target_units = 3'd1;
      ST_CHAR_GAP: w_target_units = 3'd3;
      ST_WORD_GAP: w_target_units = 3'd7;
      default:     w_target_units = 3'd1;
    endcase
  end

  // Restart timing on every state entry; hold it at zero while IDLE/LOAD.
  assign w_clear = (w_next_state != r_state) || (r_state == ST_IDLE) || (r_state == ST_LOAD);

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (w_clear),
    .target_units_i (w_target_units),
    .done_o         (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (scancode_valid_i) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (!w_pat.valid)       w_next_state = ST_IDLE;
        else if (w_pat.is_space) w_next_state = ST_WORD_GAP;
        else                    w_next_state = ST_MARK;
      end
      ST_MARK: begin
        if (w_done) w_next_state = w_last_elem ? ST_CHAR_GAP : ST_ELEM_GAP;
      end
      ST_ELEM_GAP: begin
        if (w_done) w_next_state = ST_MARK;
      end
      ST_CHAR_GAP, ST_WORD_GAP: begin
        if (w_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decode the state register only, so morse_o has no path from the
  // inputs and falls immediately when rst asynchronously forces IDLE.
  always_comb begin
    scancode_ready_o = (r_state == ST_IDLE);
    busy_o           = (r_state != ST_IDLE);
    morse_o          = (r_state == ST_MARK);
    unsupported_o    = (r_state == ST_LOAD) && !w_pat.valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= '0;
    end else if ((r_state == ST_IDLE) && scancode_valid_i) begin
      r_code <= scancode_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem <= '0;
    end else if (r_state == ST_LOAD) begin
      r_elem <= '0;
    end else if ((r_state == ST_MARK) && w_done) begin
      r_elem <= r_elem + 3'd1;
    end
  end

`ifdef MORSE_SIDETONE_EN
  localparam int TW = (TONE_HALF_PERIOD > 2) ? $clog2(TONE_HALF_PERIOD) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF_PERIOD - 1);

  logic [TW-1:0] r_tone_cnt;
  logic          r_tone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (r_state != ST_MARK) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (r_tone_cnt == TONE_LAST) begin
      r_tone_cnt <= '0;
      r_tone     <= ~r_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + 1'b1;
    end
  end

  // Gate with the state so the tone stops on the same edge the mark ends.
  assign sidetone_o = r_tone && (r_state == ST_MARK);
`endif

endmodule
